mbe_acc_stage: RTL and testbench

- Downstream consumer of the MBE multiplier wrapper's output handshake.
- Takes a stream of signed products and accumulates N consecutive products into one saturating signed sum (a dot-product block).
- Emits the sum on a valid/ready output port, with a sticky saturation flag.
- Sits between the multiplier stage and the result sink or testbench monitor.

---
 rtl/mbe_acc_stage.sv | 108 ++++++++++
 tb/tb_mbe_acc_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mbe_acc_stage.sv
// Saturating dot-product accumulator behind the MBE multiplier.
// Sums N signed products per block and emits the result on valid/ready.
module mbe_acc_stage #(
  parameter int PW = 64,
  parameter int AW = 72,
  parameter int N  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_data,
  output logic          out_sat
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [AW-1:0] MAXV = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] MINV = {1'b1, {(AW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_INIT,
    S_ACC,
    S_EMIT
  } state_e;

  state_e        state_q;
  logic [AW-1:0] acc_q;
  logic [CW-1:0] cnt_q;
  logic          sticky_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [AW-1:0] out_data_q;
  logic          out_sat_q;

  logic [AW:0]   sum_d;
  logic          clamp_d;
  logic [AW-1:0] next_d;
  logic          in_beat;
  logic          out_beat;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  assign in_beat  = in_valid && in_ready_q;
  assign out_beat = out_valid_q && out_ready;

  // One guard bit: overflow shows up as disagreement of the top two bits.
  always_comb begin
    sum_d = {acc_q[AW-1], acc_q}
          + {{(AW+1-PW){in_data[PW-1]}}, in_data};
    clamp_d = sum_d[AW] ^ sum_d[AW-1];
    next_d = sum_d[AW-1:0];
    if (clamp_d) next_d = sum_d[AW] ? MINV : MAXV;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          in_ready_q <= 1'b1;
          state_q    <= S_ACC;
        end
        S_ACC: begin
          if (in_beat) begin
            if (cnt_q == LAST) begin
              out_data_q  <= next_d;
              out_sat_q   <= sticky_q | clamp_d;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              acc_q       <= '0;
              cnt_q       <= '0;
              sticky_q    <= 1'b0;
              state_q     <= S_EMIT;
            end else begin
              acc_q    <= next_d;
              cnt_q    <= cnt_q + CW'(1);
              sticky_q <= sticky_q | clamp_d;
            end
          end
        end
        S_EMIT: begin
          if (out_beat) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_ACC;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_mbe_acc_stage.sv
// Self-checking bench for mbe_acc_stage (PW=8, AW=9, N=4).
// Table vectors, hand sequences and a random run against an integer model.
module tb_mbe_acc_stage;

  localparam int PW = 8;
  localparam int AW = 9;
  localparam int N  = 4;
  localparam int HI = 255;
  localparam int LO = -256;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [PW-1:0]        in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [AW-1:0] out_data;
  logic                 out_sat;

  int n_tests = 0;
  int n_fail  = 0;

  mbe_acc_stage #(.PW(PW), .AW(AW), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] p;
    int              sum;
    bit              sat;
    int              gap;
    int              hold;
  } vec_t;

  vec_t tbl[7];

  function automatic vec_t mk(int a, int b, int c, int d,
                              int s, bit st, int g, int h);
    vec_t v;
    v.p[0] = a[7:0];
    v.p[1] = b[7:0];
    v.p[2] = c[7:0];
    v.p[3] = d[7:0];
    v.sum  = s;
    v.sat  = st;
    v.gap  = g;
    v.hold = h;
    return v;
  endfunction

  // Reference: running sum clamped after every step.
  function automatic void model(input logic [3:0][7:0] p,
                                output int s, output bit st);
    int acc;
    acc = 0;
    st  = 1'b0;
    for (int i = 0; i < N; i++) begin
      acc = acc + int'($signed(p[i]));
      if (acc > HI) begin acc = HI; st = 1'b1; end
      if (acc < LO) begin acc = LO; st = 1'b1; end
    end
    s = acc;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(int cyc);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (cyc) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_beat(logic [7:0] p, string tag);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = p;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk({tag, " in_ready timeout"}, 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_block(logic [3:0][7:0] p, int gap, int hold,
                           int es, bit est, string tag);
    int t;
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) chk({tag, " early out_valid"}, int'(out_valid), 0);
      send_beat(p[i], tag);
      if (i < N - 1) repeat (gap) @(negedge clk);
    end
    @(negedge clk);
    chk({tag, " latency out_valid"}, int'(out_valid), 1);
    chk({tag, " in_ready in EMIT"}, int'(in_ready), 0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " out_data"}, int'(out_data), es);
    chk({tag, " out_sat"}, int'(out_sat), int'(est));
    for (int h = 0; h < hold; h++) begin
      in_valid = ~in_valid;
      in_data  = 8'($urandom);
      @(negedge clk);
      chk({tag, " hold valid"}, int'(out_valid), 1);
      chk({tag, " hold data"}, int'(out_data), es);
      chk({tag, " hold sat"}, int'(out_sat), int'(est));
      chk({tag, " hold in_ready"}, int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " post out_valid"}, int'(out_valid), 0);
    chk({tag, " post in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][7:0] rp;
    int es;
    bit est;

    tbl[0] = mk(3, -5, 7, 10, 15, 1'b0, 0, 0);
    tbl[1] = mk(127, 127, 127, -128, 127, 1'b1, 0, 1);
    tbl[2] = mk(1, 1, 1, 1, 4, 1'b0, 0, 0);
    tbl[3] = mk(-128, -128, -128, -128, -256, 1'b1, 0, 0);
    tbl[4] = mk(-128, -128, 127, 127, -2, 1'b0, 1, 5);
    tbl[5] = mk(127, 127, 127, 127, 255, 1'b1, 1, 2);
    tbl[6] = mk(100, -50, 25, -75, 0, 1'b0, 2, 0);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset in_ready", int'(in_ready), 0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_data", int'(out_data), 0);
    chk("reset out_sat", int'(out_sat), 0);
    @(negedge clk);
    chk("init in_ready", int'(in_ready), 1);
    chk("init out_valid", int'(out_valid), 0);

    foreach (tbl[i])
      run_block(tbl[i].p, tbl[i].gap, tbl[i].hold,
                tbl[i].sum, tbl[i].sat, $sformatf("tbl%0d", i));

    send_beat(8'd20, "midrst");
    send_beat(8'd30, "midrst");
    do_reset(2);
    #1 chk("midrst in_ready", int'(in_ready), 0);
    rp[0] = 8'd1;
    rp[1] = 8'd2;
    rp[2] = 8'd3;
    rp[3] = 8'd4;
    run_block(rp, 0, 0, 10, 1'b0, "midrst");

    send_beat(8'd50, "emitrst");
    send_beat(8'd50, "emitrst");
    send_beat(8'd50, "emitrst");
    send_beat(8'd50, "emitrst");
    @(negedge clk);
    chk("emitrst valid", int'(out_valid), 1);
    do_reset(1);
    #1 chk("emitrst cleared", int'(out_valid), 0);
    rp[0] = 8'd5;
    rp[1] = 8'hFF;
    rp[2] = 8'd0;
    rp[3] = 8'd2;
    run_block(rp, 0, 0, 6, 1'b0, "emitrst");

    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0: rp[i] = 8'h7F;
          1: rp[i] = 8'h80;
          default: rp[i] = 8'($urandom);
        endcase
      end
      model(rp, es, est);
      run_block(rp, $urandom_range(0, 2), $urandom_range(0, 3),
                es, est, $sformatf("rnd%0d", b));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
